// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the instruction-fetch front end and the data-side memory port.
package fetch_pkg;
  typedef enum logic [1:0] {FETCH_IDLE, FETCH_REQ, FETCH_KILL} fetch_state_e;
  typedef enum logic [1:0] {MNONE, MREAD, MWRITE} mem_cmd_e;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory bus plus decoder-side queue/redirect/link signals of the fetch unit.
interface fetch_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_ack_i;
  logic [DATA_W-1:0] imem_rdata_i;
  logic              ir_valid_o;
  logic [DATA_W-1:0] ir_o;
  logic [ADDR_W-1:0] ir_pc_o;
  logic              ir_take_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              link_load_i;
  logic [ADDR_W-1:0] link_pc_o;
  modport master (
    output imem_req_o, imem_addr_o, ir_valid_o, ir_o, ir_pc_o, link_pc_o,
    input  imem_ack_i, imem_rdata_i, ir_take_i, redirect_i, redirect_pc_i, link_load_i
  );
  modport slave (
    input  imem_req_o, imem_addr_o, ir_valid_o, ir_o, ir_pc_o, link_pc_o,
    output imem_ack_i, imem_rdata_i, ir_take_i, redirect_i, redirect_pc_i, link_load_i
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch queue with flush; head is read straight from the storage registers.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       din_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] cnt_o
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, wr_q;
  logic [PW:0]      cnt_q;
  logic             pop;
  assign pop = pop_i & (cnt_q != '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{PW{1'b0}}, push_i} - {{PW{1'b0}}, pop};
    end
  end
  assign head_o  = mem_q[rd_q];
  assign valid_o = cnt_q != '0;
  assign cnt_o   = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: decoupled instruction fetch with prefetch queue, redirect flush and BL link register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              ADDR_W   = 9,
  parameter int              DATA_W   = 16,
  parameter int              DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst_n,
  fetch_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_e             state_q, state_d;
  logic [ADDR_W-1:0]        fpc_q, fpc_d, addr_q, addr_d, link_q;
  logic [CW-1:0]            occ, occ_pop, occ_push;
  logic                     valid, pop, push, ack, red;
  logic [ADDR_W+DATA_W-1:0] head;
  assign ack      = bus.imem_ack_i;
  assign red      = bus.redirect_i;
  assign pop      = bus.ir_take_i & valid & ~red;
  assign push     = (state_q == FETCH_REQ) & ack & ~red;
  assign occ_pop  = occ - CW'(pop);
  assign occ_push = occ_pop + CW'(push);
  fetch_fifo #(.WIDTH(ADDR_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(push), .pop_i(pop), .flush_i(red),
    .din_i({addr_q, bus.imem_rdata_i}), .head_o(head), .valid_o(valid), .cnt_o(occ)
  );
  // A request is only issued when the queue is guaranteed room for its response.
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    addr_d  = addr_q;
    if (red) begin
      fpc_d = bus.redirect_pc_i;
      if (state_q == FETCH_IDLE || ack) begin
        state_d = FETCH_REQ;
        addr_d  = bus.redirect_pc_i;
      end else state_d = FETCH_KILL;
    end else if (state_q == FETCH_IDLE) begin
      if (occ_pop < CW'(DEPTH)) begin
        state_d = FETCH_REQ;
        addr_d  = fpc_q;
      end
    end else if (ack && state_q == FETCH_REQ) begin
      fpc_d   = fpc_q + 1'b1;
      addr_d  = fpc_q + 1'b1;
      state_d = occ_push < CW'(DEPTH) ? FETCH_REQ : FETCH_IDLE;
    end else if (ack) begin
      state_d = FETCH_REQ;
      addr_d  = fpc_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH_IDLE;
      fpc_q   <= RESET_PC;
      addr_q  <= RESET_PC;
      link_q  <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      addr_q  <= addr_d;
      if (bus.link_load_i && valid) link_q <= bus.ir_pc_o + 1'b1;
    end
  end
  assign bus.imem_req_o  = state_q != FETCH_IDLE;
  assign bus.imem_addr_o = addr_q;
  assign bus.ir_valid_o  = valid;
  assign bus.ir_pc_o     = head[ADDR_W+DATA_W-1:DATA_W];
  assign bus.ir_o        = head[DATA_W-1:0];
  assign bus.link_pc_o   = link_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random stimulus against a queue-based reference model of the fetch engine.
module tb_fetch_unit;
  localparam int AW = 9;
  localparam int DW = 16;
  localparam int DEPTH = 2;
  localparam logic [AW-1:0] RST_PC = 9'h1FE;
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] d;
  } ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail = 0;
  ent_t q[$];
  logic [AW-1:0] m_fpc, m_addr, m_link;
  bit m_req, m_kill;
  int lat_left, max_lat;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return 16'hA000 + {7'b0, a};
  endfunction
  task automatic model_reset();
    q.delete();
    m_fpc = RST_PC;
    m_addr = RST_PC;
    m_link = '0;
    m_req = 0;
    m_kill = 0;
    lat_left = 0;
  endtask
  task automatic zero_inputs();
    bus.imem_ack_i = 0;
    bus.imem_rdata_i = '0;
    bus.ir_take_i = 0;
    bus.redirect_i = 0;
    bus.redirect_pc_i = '0;
    bus.link_load_i = 0;
  endtask
  task automatic reset_checks();
    check("rst_req", bus.imem_req_o, 1'b0);
    check("rst_addr", bus.imem_addr_o, RST_PC);
    check("rst_valid", bus.ir_valid_o, 1'b0);
    check("rst_ir", bus.ir_o, 16'h0);
    check("rst_ir_pc", bus.ir_pc_o, 9'h0);
    check("rst_link", bus.link_pc_o, 9'h0);
  endtask
  task automatic check_outputs();
    check("req", bus.imem_req_o, m_req);
    if (m_req) check("addr", bus.imem_addr_o, m_addr);
    check("valid", bus.ir_valid_o, q.size() > 0);
    if (q.size() > 0) begin
      check("ir_pc", bus.ir_pc_o, q[0].pc);
      check("ir", bus.ir_o, q[0].d);
    end
    check("link", bus.link_pc_o, m_link);
  endtask
  // One clock: drive inputs, advance the model by the spec's rules, then compare at the falling edge.
  task automatic step_with(input bit red, input logic [AW-1:0] rpc, input bit ll, input bit take);
    bit ack, was_req;
    ack = m_req && lat_left == 0;
    if (m_req && lat_left > 0) lat_left--;
    bus.ir_take_i = take;
    bus.redirect_i = red;
    bus.redirect_pc_i = rpc;
    bus.link_load_i = ll;
    bus.imem_ack_i = ack;
    bus.imem_rdata_i = ack ? mem(m_addr) : DW'($urandom);
    was_req = m_req;
    if (ll && q.size() > 0) m_link = q[0].pc + 1'b1;
    if (red) begin
      q.delete();
      m_fpc = rpc;
      if (!m_req || ack) begin
        m_req = 1;
        m_kill = 0;
        m_addr = rpc;
      end else m_kill = 1;
    end else begin
      if (take && q.size() > 0) void'(q.pop_front());
      if (!m_req) begin
        if (q.size() < DEPTH) begin
          m_req = 1;
          m_addr = m_fpc;
        end
      end else if (ack) begin
        if (!m_kill) begin
          q.push_back('{pc: m_addr, d: mem(m_addr)});
          m_fpc = m_fpc + 1'b1;
        end
        m_kill = 0;
        m_req = q.size() < DEPTH;
        m_addr = m_fpc;
      end
    end
    if (m_req && (ack || !was_req)) lat_left = $urandom_range(0, max_lat);
    @(negedge clk);
    check_outputs();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    zero_inputs();
    max_lat = 0;
    model_reset();
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    reset_checks();
    rst_n = 1;
    repeat (8) step_with(0, '0, 0, 1);
    max_lat = 3;
    repeat (14) step_with(0, '0, 0, 0);
    check("full_req_low", bus.imem_req_o, 1'b0);
    step_with(0, '0, 0, 1);
    check("req_after_pop", bus.imem_req_o, 1'b1);
    max_lat = 2;
    step_with(1, 9'h010, 0, 0);
    for (int i = 0; i < 20 && q.size() == 0; i++) step_with(0, '0, 0, 0);
    check("head_010", bus.ir_pc_o, 9'h010);
    step_with(1, 9'h040, 1, 0);
    check("link_bl", bus.link_pc_o, 9'h011);
    check("flush_valid", bus.ir_valid_o, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) max_lat = $urandom_range(0, 3);
      step_with($urandom_range(0, 99) < 8,
                ($urandom_range(0, 3) == 0) ? 9'h1FF : AW'($urandom),
                $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 60);
    end
    for (int i = 0; i < 20 && !m_req; i++) step_with(0, '0, 0, 1);
    check("pre_reset_req", bus.imem_req_o, 1'b1);
    zero_inputs();
    #2 rst_n = 0;
    #1;
    check("async_req", bus.imem_req_o, 1'b0);
    check("async_valid", bus.ir_valid_o, 1'b0);
    model_reset();
    @(negedge clk);
    reset_checks();
    rst_n = 1;
    max_lat = 1;
    repeat (12) step_with(0, '0, 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the next-generation Simple RISC Machine core. It replaces the single-shot PC, instruction-register and branch-link path with a decoupled fetch engine. The engine supports variable-latency instruction memory, a prefetch queue of configurable depth, branch redirect with queue flush, and a link register for BL. It sits between instruction memory and the control FSM/instruction decoder.

## Interface
- ADDR_W, 9, address and PC width
- DATA_W, 16, instruction width
- DEPTH, 2, prefetch queue entries (power of two, ≥2)
- RESET_PC, 0, first fetch address after reset
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request; held with stable imem_addr until acknowledged
- imem_addr  out  ADDR_W  fetch address
- imem_ack  in  1  one-cycle acknowledge; imem_rdata valid in the same cycle
- imem_rdata  in  DATA_W  fetched instruction
- ir_valid  out  1  queue head valid
- ir  out  DATA_W  instruction at queue head
- ir_pc  out  ADDR_W  address of the head instruction
- ir_take  in  1  consumer pops head; ignored when ir_valid=0
- redirect  in  1  taken branch or return; flush and refetch
- redirect_pc  in  ADDR_W  redirect target
- link_load  in  1  capture ir_pc+1 into link register (BL)
- link_pc  out  ADDR_W  link register value

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - REQ: imem_req=1 at fpc.
  - KILL: imem_req=1; the response will be discarded.
- fpc is the next fetch address. occ is the queue occupancy.
- IDLE→REQ when occ_next < DEPTH. Issue a request only if the queue has room for its response.
- REQ and ack without redirect:
  - Push {fpc, imem_rdata} into the queue.
  - fpc ← fpc+1, modulo 2^ADDR_W (wraps to 0).
  - Stay in REQ (back-to-back fetch at the new fpc) if occ after push/pop < DEPTH; else go to IDLE.
- REQ without ack: hold imem_addr. The address must not change while a request is pending.
- Redirect:
  - Queue flushes (occ←0) and fpc←redirect_pc.
  - From IDLE, or from REQ/KILL with ack in the same cycle: drop any ack data and go to REQ at the target next cycle.
  - From REQ/KILL without ack: go to KILL. The pending address stays on the bus; fpc already holds the target.
- KILL: on ack, discard data, no push, go to REQ at fpc. A second redirect in KILL only updates fpc.
- Simultaneous push and pop is allowed at any occupancy with ir_valid=1. occ is unchanged.
- Redirect has priority over ir_take and push in the same cycle.
- link_load with ir_valid=1: link_pc ← ir_pc+1 (wrapping), sampled before any same-cycle flush. link_load with ir_valid=0 is ignored.
- Reset values:
  - imem_req=0, imem_addr=RESET_PC, fpc=RESET_PC
  - ir_valid=0, ir=0, ir_pc=0, link_pc=0
  - occ=0, state IDLE

## Timing
- Reset released before edge t0 → imem_req=1, imem_addr=RESET_PC after edge t0.
- Zero-wait memory (ack in the request's first cycle) sustains one fetch per cycle while the consumer pops every cycle.
- Fetch latency: ack at cycle c into an empty queue → ir_valid=1 at c+1. Queue outputs are registered.
- Redirect at cycle t with no request pending → imem_addr=redirect_pc at t+1; with zero-wait ack, target is at the head at t+2.
- Redirect at t with a request pending and ack arriving at t+k → target requested at t+k+1.
- ir_valid drops in the cycle after a redirect, regardless of ir_take.
- DEPTH full: imem_req stays low until a pop. The request rises the cycle after the pop edge.

## Structure
- Shared package fetch_pkg:
  - state enum FETCH_IDLE, FETCH_REQ, FETCH_KILL
  - MREAD/MWRITE/MNONE mem_cmd encodings (reused by the data-side port)
- Sub-module fetch_fifo:
  - synchronous FIFO, parameters WIDTH and DEPTH
  - push, pop and flush inputs; registered head; occupancy output
  - same async active-low reset
- Address arithmetic is unsigned modulo 2^ADDR_W. No overflow flag.

## Test plan
- Reset, zero-wait memory returning mem[a]=16'hA000+a, ir_take held high → ir_pc sequence 0,1,2,3 on consecutive cycles from the first ir_valid. Check ir matches mem[ir_pc].
- ack delayed 3 cycles, ir_take=0, DEPTH=2 → exactly two requests (addr 0,1). imem_req low while full. One pop → request for addr 2 the next cycle.
- Redirect to 9'h040 at the cycle the addr-5 request is pending, ack arrives 2 cycles later → addr-5 data never appears. Next request is 9'h040; first ir_pc=9'h040.
- Redirect plus link_load at head ir_pc=9'h010 → link_pc=9'h011, queue flushed, ir_valid=0 next cycle.
- ADDR_W=9, RESET_PC=9'h1FE, ir_take=1 → ir_pc sequence 1FE,1FF,000,001.
- Reset asserted mid-request → imem_req=0 and ir_valid=0 immediately (asynchronous). After release, fetch restarts at RESET_PC.
